imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the 32-bit MIPS instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Drives a write port into instruction memory at byte addresses 0, 4, 8, …
- Verifies a trailing XOR checksum and holds the CPU until a load completes successfully.

Parameters:
- WIDTH, 32, instruction word width and write-address width; must be 32.
- DEPTH, 100, instruction memory depth in words; the upper limit on the word count.
- CNT_W, 8, width of the word-count input.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- Loader_Start  input  1  one-cycle pulse that starts a load; sampled only in IDLE, DONE and ERROR.
- Loader_WordCount  input  CNT_W  number of words to load; sampled on the accepted Start.
- Loader_Byte  input  8  stream data byte.
- Loader_ByteValid  input  1  Loader_Byte is valid this cycle.
- Loader_ByteReady  output  1  loader accepts a byte this cycle.
- Loader_WrEn  output  1  instruction memory write strobe, one cycle per word.
- Loader_WrAddr  output  WIDTH  byte address of the word being written, always a multiple of 4.
- Loader_WrData  output  WIDTH  assembled instruction word.
- Loader_CpuHold  output  1  high keeps the CPU stalled or in reset.
- Loader_Done  output  1  load completed and checksum matched; sticky.
- Loader_Error  output  1  bad count or checksum mismatch; sticky.

Behaviour:
- Reset values on RST=1 (takes priority over everything, in any state):
  - state = IDLE.
  - ByteReady=0, WrEn=0, WrAddr=0, WrData=0.
  - CpuHold=1, Done=0, Error=0.
  - Internal byte index, word index, shift register and running XOR all cleared.
  - A partially assembled word is discarded; no write issues after reset.
- Handshake: a byte transfers in a cycle where ByteValid=1 and ByteReady=1. ByteReady is registered and depends only on state: 1 in RECV and CSUM, 0 elsewhere.
- States:
  - IDLE: waits for Start.
    - Start with WordCount == 0 or WordCount > DEPTH: go to ERROR next cycle, with Error=1 and no writes.
    - Otherwise latch the count, clear the word index and XOR, and go to RECV next cycle.
  - RECV: each accepted byte shifts in MSB-first (1st byte to [31:24], 4th byte to [7:0]) and is XORed into the running checksum.
    - On the 4th byte go to WRITE.
  - WRITE: exactly one cycle.
    - WrEn=1, WrAddr = word_index*4, WrData = assembled word.
    - Then increment word_index.
    - If the new word_index equals the count, go to CSUM; otherwise go to RECV.
  - CSUM: accept exactly one byte.
    - If it equals the running XOR, go to DONE; otherwise go to ERROR.
  - DONE: Done=1, CpuHold=0.
  - ERROR: Error=1, CpuHold=1.
  - Start in DONE or ERROR behaves as in IDLE. Done, Error and the XOR clear on the cycle after Start, and CpuHold returns to 1.
- Start in RECV, WRITE or CSUM is ignored.
- CpuHold=1 in every state except DONE.
- WrEn is 0 in every state except WRITE. WrAddr and WrData hold their last value when WrEn=0.
- Latency:
  - Start accepted at cycle t gives ByteReady=1 at t+1.
  - 4th byte of a word accepted at cycle n gives WrEn=1 at n+1, and ByteReady=1 again at n+2.
  - Checksum byte accepted at cycle m gives Done or Error at m+1.
- Gaps (ByteValid=0) stall indefinitely with no timeout, and the internal state holds.
- WordCount == DEPTH is legal. The last write goes to address (DEPTH-1)*4 = 396, and word_index never exceeds DEPTH.

Test Plan:
- Reset: assert RST for 2 cycles mid-anything -> ByteReady=0, WrEn=0, WrAddr=0, WrData=0, CpuHold=1, Done=0, Error=0.
- Nominal load: Start with WordCount=2; bytes 12 34 56 78 AA BB CC DD, then checksum 08, all back-to-back.
  - Writes: addr 0 data 0x12345678, then addr 4 data 0xAABBCCDD.
  - One cycle after the checksum byte: Done=1, CpuHold=0, Error=0.
- Checksum mismatch: same stream with checksum 09 -> both writes still occur; then Error=1, Done=0, CpuHold=1.
- Bad counts:
  - WordCount=0 -> Error=1 next cycle, no WrEn.
  - WordCount=101 -> same response.
  - WordCount=100 with a correct checksum -> last write at addr 396 (0x18C), then Done=1.
- Gaps and ignored Start: WordCount=1, ByteValid toggling 1,0,0,1,1,0,1, plus a Start pulse during RECV -> Start ignored, a single write at addr 0 after the 4th accepted byte, no extra bytes consumed.
- Reset mid-load: RST for one cycle after 3 bytes of word 1, then a fresh WordCount=1 load of 01 02 03 04 with checksum 04 -> write addr 0 data 0x01020304 (no residue of the earlier bytes), then Done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian words from a byte stream and writes them into instruction memory.
// Latency: Start->ByteReady 1 cycle; 4th byte->WrEn 1 cycle; checksum byte->Done/Error 1 cycle.
// Backpressure: ByteReady is high only in RECV/CSUM; gaps in ByteValid stall the loader indefinitely.
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 100,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Loader_Start,
    input  logic [CNT_W-1:0] Loader_WordCount,
    input  logic [7:0]       Loader_Byte,
    input  logic             Loader_ByteValid,
    output logic             Loader_ByteReady,
    output logic             Loader_WrEn,
    output logic [WIDTH-1:0] Loader_WrAddr,
    output logic [WIDTH-1:0] Loader_WrData,
    output logic             Loader_CpuHold,
    output logic             Loader_Done,
    output logic             Loader_Error
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] word_idx_q;
    logic [1:0]       byte_idx_q;
    logic [23:0]      shift_q;
    logic [7:0]       xor_q;
    logic [WIDTH-1:0] wr_addr_q;
    logic [WIDTH-1:0] wr_data_q;

    // Start is only honoured when no load is in flight.
    logic start_ok;
    logic count_bad;
    logic accept;

    assign start_ok  = Loader_Start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign count_bad = (Loader_WordCount == '0) || (Loader_WordCount > DEPTH_C);
    assign accept    = Loader_ByteValid && Loader_ByteReady;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d          = state_q;
        Loader_ByteReady = 1'b0;
        Loader_WrEn      = 1'b0;
        Loader_CpuHold   = 1'b1;
        Loader_Done      = 1'b0;
        Loader_Error     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                Loader_Done    = (state_q == S_DONE);
                Loader_Error   = (state_q == S_ERROR);
                Loader_CpuHold = (state_q != S_DONE);
                if (start_ok) state_d = count_bad ? S_ERROR : S_RECV;
            end
            S_RECV: begin
                Loader_ByteReady = 1'b1;
                if (accept && byte_idx_q == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: begin
                Loader_WrEn = 1'b1;
                state_d = (word_idx_q + CNT_W'(1) == count_q) ? S_CSUM : S_RECV;
            end
            S_CSUM: begin
                Loader_ByteReady = 1'b1;
                if (accept) state_d = (Loader_Byte == xor_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: count latch, byte assembly, running XOR and write-port registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            xor_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else if (start_ok) begin
            // A bad count leaves the stale count latched; it is never used from ERROR.
            if (!count_bad) count_q <= Loader_WordCount;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            xor_q      <= '0;
        end else if (state_q == S_RECV && accept) begin
            shift_q    <= {shift_q[15:0], Loader_Byte};
            xor_q      <= xor_q ^ Loader_Byte;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                wr_data_q <= {shift_q, Loader_Byte};
                wr_addr_q <= WIDTH'({word_idx_q, 2'b00});
            end
        end else if (state_q == S_WRITE) begin
            word_idx_q <= word_idx_q + CNT_W'(1);
        end
    end

    assign Loader_WrAddr = wr_addr_q;
    assign Loader_WrData = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scoreboard of expected writes popped by a write monitor, plus flag checks.
// Latency: checks flags on the negedge following each relevant accepting edge.
// Backpressure: byte driver holds ByteValid until ByteReady is seen, with a bounded wait.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Loader_Start;
    logic [7:0]  Loader_WordCount;
    logic [7:0]  Loader_Byte;
    logic        Loader_ByteValid;
    logic        Loader_ByteReady;
    logic        Loader_WrEn;
    logic [31:0] Loader_WrAddr;
    logic [31:0] Loader_WrData;
    logic        Loader_CpuHold;
    logic        Loader_Done;
    logic        Loader_Error;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] exp_q[$];
    int          tb_widx;
    logic [7:0]  tb_xor;

    imem_loader #(.WIDTH(32), .DEPTH(100), .CNT_W(8)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .Loader_Start     (Loader_Start),
        .Loader_WordCount (Loader_WordCount),
        .Loader_Byte      (Loader_Byte),
        .Loader_ByteValid (Loader_ByteValid),
        .Loader_ByteReady (Loader_ByteReady),
        .Loader_WrEn      (Loader_WrEn),
        .Loader_WrAddr    (Loader_WrAddr),
        .Loader_WrData    (Loader_WrData),
        .Loader_CpuHold   (Loader_CpuHold),
        .Loader_Done      (Loader_Done),
        .Loader_Error     (Loader_Error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Write monitor: every WrEn must match the oldest expected write.
    initial begin
        forever begin
            @(negedge CLK);
            if (Loader_WrEn === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr_addr", {32'd0, Loader_WrAddr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {32'd0, Loader_WrAddr}, {32'd0, e[63:32]});
                    chk("wr_data", {32'd0, Loader_WrData}, {32'd0, e[31:0]});
                end
            end
        end
    end

    // All drivers enter and leave at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        Loader_Byte      = b;
        Loader_ByteValid = 1'b1;
        while (t < 200) begin
            @(negedge CLK);
            if (Loader_ByteReady === 1'b1) break;
            t++;
        end
        if (t >= 200) chk("byte_ready_timeout", 64'd0, 64'd1);
        @(posedge CLK); #1;
        Loader_ByteValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) begin
            logic [7:0] b;
            b = w[k*8 +: 8];
            tb_xor = tb_xor ^ b;
            if (k == 0) begin
                exp_q.push_back({32'(tb_widx * 4), w});
                tb_widx++;
            end
            send_byte(b);
        end
    endtask

    task automatic start(input logic [7:0] cnt);
        Loader_WordCount = cnt;
        Loader_Start     = 1'b1;
        @(posedge CLK); #1;
        Loader_Start     = 1'b0;
        tb_widx = 0;
        tb_xor  = 8'h00;
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err, input logic hold);
        @(negedge CLK);
        chk({tag, "_done"}, {63'd0, Loader_Done},    {63'd0, done});
        chk({tag, "_err"},  {63'd0, Loader_Error},   {63'd0, err});
        chk({tag, "_hold"}, {63'd0, Loader_CpuHold}, {63'd0, hold});
        @(posedge CLK); #1;
    endtask

    task automatic check_reset();
        @(negedge CLK);
        chk("rst_ready",  {63'd0, Loader_ByteReady}, 64'd0);
        chk("rst_wren",   {63'd0, Loader_WrEn},      64'd0);
        chk("rst_addr",   {32'd0, Loader_WrAddr},    64'd0);
        chk("rst_data",   {32'd0, Loader_WrData},    64'd0);
        chk("rst_hold",   {63'd0, Loader_CpuHold},   64'd1);
        chk("rst_done",   {63'd0, Loader_Done},      64'd0);
        chk("rst_err",    {63'd0, Loader_Error},     64'd0);
        @(posedge CLK); #1;
    endtask

    task automatic drain_check(input string tag);
        repeat (2) @(posedge CLK);
        #1;
        chk(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [1:0] vpat [7];
        int         bi;
        logic [7:0] gbytes [4];

        RST = 1'b1; Loader_Start = 1'b0; Loader_WordCount = 8'd0;
        Loader_Byte = 8'd0; Loader_ByteValid = 1'b0;
        tb_widx = 0; tb_xor = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check_reset();
        RST = 1'b0;

        // Nominal two-word load with correct checksum.
        start(8'd2);
        @(negedge CLK);
        chk("start_to_ready", {63'd0, Loader_ByteReady}, 64'd1);
        @(posedge CLK); #1;
        send_word(32'h12345678);
        send_word(32'hAABBCCDD);
        chk("nominal_xor_model", {56'd0, tb_xor}, 64'h08);
        send_byte(tb_xor);
        check_flags("nominal", 1'b1, 1'b0, 1'b0);
        drain_check("nominal_writes");

        // Same stream, wrong checksum; started from DONE.
        start(8'd2);
        check_flags("restart_clears", 1'b0, 1'b0, 1'b1);
        send_word(32'h12345678);
        send_word(32'hAABBCCDD);
        send_byte(8'h09);
        check_flags("bad_csum", 1'b0, 1'b1, 1'b1);
        drain_check("bad_csum_writes");

        // Illegal word counts go straight to ERROR with no writes.
        start(8'd0);
        check_flags("cnt0", 1'b0, 1'b1, 1'b1);
        start(8'd101);
        check_flags("cnt101", 1'b0, 1'b1, 1'b1);
        drain_check("bad_cnt_no_writes");

        // Full-depth load: last write lands at 396.
        start(8'd100);
        for (int i = 0; i < 100; i++) send_word(32'(i * 32'h01030507 + 32'h9E37_79B9));
        send_byte(tb_xor);
        check_flags("depth", 1'b1, 1'b0, 1'b0);
        drain_check("depth_writes");

        // Gapped stream plus a stray Start while receiving.
        start(8'd1);
        vpat[0] = 2'd1; vpat[1] = 2'd0; vpat[2] = 2'd2; vpat[3] = 2'd1;
        vpat[4] = 2'd1; vpat[5] = 2'd0; vpat[6] = 2'd1;
        gbytes[0] = 8'hA1; gbytes[1] = 8'hB2; gbytes[2] = 8'hC3; gbytes[3] = 8'hD4;
        exp_q.push_back({32'd0, 32'hA1B2C3D4});
        tb_xor = 8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4;
        bi = 0;
        for (int c = 0; c < 7; c++) begin
            // 2 marks a gap cycle carrying a stray Start and a garbage byte.
            Loader_ByteValid = (vpat[c] == 2'd1);
            Loader_Start     = (vpat[c] == 2'd2);
            Loader_WordCount = 8'd3;
            Loader_Byte      = (vpat[c] == 2'd1) ? gbytes[bi] : 8'hEE;
            if (vpat[c] == 2'd1) bi++;
            @(posedge CLK); #1;
        end
        Loader_ByteValid = 1'b0; Loader_Start = 1'b0;
        send_byte(tb_xor);
        check_flags("gaps", 1'b1, 1'b0, 1'b0);
        drain_check("gaps_writes");

        // Reset mid-load discards the partial word.
        start(8'd2);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_hold", {63'd0, Loader_CpuHold},   64'd1);
        chk("midrst_ready", {63'd0, Loader_ByteReady}, 64'd0);
        @(posedge CLK); #1;
        start(8'd1);
        send_word(32'h01020304);
        chk("midrst_xor_model", {56'd0, tb_xor}, 64'h04);
        send_byte(tb_xor);
        check_flags("midrst", 1'b1, 1'b0, 1'b0);
        drain_check("midrst_writes");

        // Two-cycle reset from DONE.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_reset();
        RST = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
